flash_cmd_sequencer: RTL and testbench

//   Tracks JEDEC command sequences the CPU writes to the PRG flash ($8000-$FFFF) and schedules flash write access.
//   It decodes the unlock/program/erase cycles and times the embedded program/erase operation.
//   It blocks flash_we while the flash is busy and reports busy, done and error status to the mapper register file.
//   It sits beside the top-level flash_we/flash_oe logic, clocked by CPU m2.

---
 rtl/flash_cmd_sequencer.sv | 146 ++++++++++++++
 tb/tb_flash_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// flash_cmd_sequencer : JEDEC command decoder and busy timer for PRG flash
// Rev 1.0
// ============================================================================
module flash_cmd_sequencer #(
   parameter logic [11:0]           UNLOCK_ADDR1         = 12'hAAA,
   parameter logic [11:0]           UNLOCK_ADDR2         = 12'h555,
   parameter int                    TIMER_BITS           = 24,
   parameter logic [TIMER_BITS-1:0] PROG_TIMEOUT         = TIMER_BITS'(40),
   parameter logic [TIMER_BITS-1:0] SECTOR_ERASE_TIMEOUT = TIMER_BITS'(900000),
   parameter logic [TIMER_BITS-1:0] CHIP_ERASE_TIMEOUT   = TIMER_BITS'(16000000)
) (
   input  logic        m2,
   input  logic        reset,
   input  logic        prg_write_enabled,
   input  logic        bus_write,
   input  logic [14:0] cpu_addr_in,
   input  logic [7:0]  cpu_data_in,
   output logic        flash_we_block,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_U1      = 4'd1,
      ST_U2      = 4'd2,
      ST_PROG    = 4'd3,
      ST_E_SETUP = 4'd4,
      ST_E_U1    = 4'd5,
      ST_E_U2    = 4'd6,
      ST_AUTOSEL = 4'd7,
      ST_BUSY    = 4'd8
   } state_t;

   localparam logic [TIMER_BITS-1:0] C_ONE = TIMER_BITS'(1);

   state_t                r_state;
   logic [TIMER_BITS-1:0] r_timer;
   logic                  r_done;
   logic                  r_error;

   logic w_hit_a1;
   logic w_hit_a2;

   assign w_hit_a1 = (cpu_addr_in[11:0] == UNLOCK_ADDR1);
   assign w_hit_a2 = (cpu_addr_in[11:0] == UNLOCK_ADDR2);

   // A zero timeout still has to produce one busy cycle and a done pulse.
   function automatic logic [TIMER_BITS-1:0] load_val(input logic [TIMER_BITS-1:0] v);
      return (v == '0) ? C_ONE : v;
   endfunction

   always_ff @(posedge m2) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else if (!prg_write_enabled) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == ST_BUSY) begin
            if (bus_write) begin
               r_error <= 1'b1;
            end
            if (r_timer <= C_ONE) begin
               r_state <= ST_IDLE;
               r_timer <= '0;
               r_done  <= 1'b1;
            end else begin
               r_timer <= r_timer - C_ONE;
            end
         end else if (bus_write) begin
            case (r_state)
               ST_IDLE: begin
                  if (cpu_data_in == 8'hAA && w_hit_a1) begin
                     r_state <= ST_U1;
                  end else if (cpu_data_in == 8'hF0) begin
                     r_error <= 1'b0;
                  end
               end
               ST_U1: begin
                  r_state <= (cpu_data_in == 8'h55 && w_hit_a2) ? ST_U2 : ST_IDLE;
               end
               ST_U2: begin
                  if (cpu_data_in == 8'hA0 && w_hit_a1) begin
                     r_state <= ST_PROG;
                  end else if (cpu_data_in == 8'h80 && w_hit_a1) begin
                     r_state <= ST_E_SETUP;
                  end else if (cpu_data_in == 8'h90 && w_hit_a1) begin
                     r_state <= ST_AUTOSEL;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
               ST_PROG: begin
                  r_state <= ST_BUSY;
                  r_timer <= load_val(PROG_TIMEOUT);
               end
               ST_E_SETUP: begin
                  r_state <= (cpu_data_in == 8'hAA && w_hit_a1) ? ST_E_U1 : ST_IDLE;
               end
               ST_E_U1: begin
                  r_state <= (cpu_data_in == 8'h55 && w_hit_a2) ? ST_E_U2 : ST_IDLE;
               end
               ST_E_U2: begin
                  if (cpu_data_in == 8'h30) begin
                     r_state <= ST_BUSY;
                     r_timer <= load_val(SECTOR_ERASE_TIMEOUT);
                  end else if (cpu_data_in == 8'h10 && w_hit_a1) begin
                     r_state <= ST_BUSY;
                     r_timer <= load_val(CHIP_ERASE_TIMEOUT);
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
               ST_AUTOSEL: begin
                  if (cpu_data_in == 8'hF0) begin
                     r_state <= ST_IDLE;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_timer <= '0;
               end
            endcase
         end
      end
   end

   // Combinational from the registered state so the write that enters BUSY still reaches the flash.
   assign busy           = (r_state == ST_BUSY);
   assign flash_we_block = busy | ~prg_write_enabled;
   assign done           = r_done;
   assign error          = r_error;
   assign state_dbg      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_flash_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_flash_cmd_sequencer : scoreboard bench with a sequence-matching model
// Rev 1.0
// ============================================================================
module tb_flash_cmd_sequencer;

   localparam int PT = 40;
   localparam int ST = 100;
   localparam int CT = 200;

   logic        m2 = 1'b0;
   logic        reset = 1'b1;
   logic        prg_write_enabled = 1'b1;
   logic        bus_write = 1'b0;
   logic [14:0] cpu_addr_in = '0;
   logic [7:0]  cpu_data_in = '0;
   logic        flash_we_block;
   logic        busy;
   logic        done;
   logic        error;
   logic [3:0]  state_dbg;

   flash_cmd_sequencer #(
      .PROG_TIMEOUT        (24'd40),
      .SECTOR_ERASE_TIMEOUT(24'd100),
      .CHIP_ERASE_TIMEOUT  (24'd200)
   ) dut (
      .m2               (m2),
      .reset            (reset),
      .prg_write_enabled(prg_write_enabled),
      .bus_write        (bus_write),
      .cpu_addr_in      (cpu_addr_in),
      .cpu_data_in      (cpu_data_in),
      .flash_we_block   (flash_we_block),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .state_dbg        (state_dbg)
   );

   always #5 m2 = ~m2;

   typedef struct packed {
      logic busy;
      logic done;
      logic error;
      logic block;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // Command templates: token = {sel[1:0], data[7:0]}; sel 0=any addr, 1=A1, 2=A2, 3=any data/addr
   int tmpl [4][6];
   int tlen [4];
   int hist [$];
   bit m_auto = 0;
   int m_cnt  = 0;
   bit m_done = 0;
   bit m_err  = 0;
   bit known  = 0;
   bit pwe_cur = 1;

   initial begin
      tmpl[0] = '{'h1AA, 'h255, 'h1A0, 'h300, 0, 0};        tlen[0] = 4;
      tmpl[1] = '{'h1AA, 'h255, 'h180, 'h1AA, 'h255, 'h030}; tlen[1] = 6;
      tmpl[2] = '{'h1AA, 'h255, 'h180, 'h1AA, 'h255, 'h110}; tlen[2] = 6;
      tmpl[3] = '{'h1AA, 'h255, 'h190, 0, 0, 0};             tlen[3] = 3;
   end

   function automatic bit tok_match(int tk, int wr);
      logic [1:0]  sel;
      logic [7:0]  td;
      logic [14:0] a;
      logic [7:0]  d;
      sel = tk[9:8];
      td  = tk[7:0];
      a   = wr[22:8];
      d   = wr[7:0];
      if (sel == 2'd3) return 1'b1;
      if (d != td) return 1'b0;
      if (sel == 2'd1) return a[11:0] == 12'hAAA;
      if (sel == 2'd2) return a[11:0] == 12'h555;
      return 1'b1;
   endfunction

   task automatic classify(logic [14:0] a, logic [7:0] d);
      bit any_pref;
      int full;
      if (hist.size() == 0 && d == 8'hF0) m_err = 0;
      hist.push_back({9'd0, a, d});
      any_pref = 0;
      full = -1;
      for (int t = 0; t < 4; t++) begin
         bit ok;
         ok = (hist.size() <= tlen[t]);
         for (int i = 0; i < hist.size() && ok; i++)
            if (!tok_match(tmpl[t][i], hist[i])) ok = 0;
         if (ok) begin
            any_pref = 1;
            if (hist.size() == tlen[t]) full = t;
         end
      end
      if (!any_pref) hist.delete();
      else if (full >= 0) begin
         case (full)
            0: m_cnt = PT;
            1: m_cnt = ST;
            2: m_cnt = CT;
            default: m_auto = 1;
         endcase
         hist.delete();
      end
   endtask

   task automatic model_step(bit r, bit pwe, bit bw, logic [14:0] a, logic [7:0] d);
      if (r) begin
         hist.delete(); m_auto = 0; m_cnt = 0; m_done = 0; m_err = 0;
      end else if (!pwe) begin
         hist.delete(); m_auto = 0; m_cnt = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (m_cnt > 0) begin
            if (bw) m_err = 1;
            if (m_cnt == 1) begin
               m_cnt = 0;
               m_done = 1;
            end else m_cnt--;
         end else if (m_auto) begin
            if (bw && d == 8'hF0) m_auto = 0;
         end else if (bw) classify(a, d);
      end
   endtask

   // Drive one cycle: inputs change on the falling edge and are sampled on the next rising edge.
   task automatic drive(bit r, bit pwe, bit bw, logic [14:0] a, logic [7:0] d);
      exp_t e;
      @(negedge m2);
      reset = r;
      prg_write_enabled = pwe;
      bus_write = bw;
      cpu_addr_in = a;
      cpu_data_in = d;
      if (known) begin
         e.busy  = (m_cnt > 0);
         e.done  = m_done;
         e.error = m_err;
         e.block = (m_cnt > 0) | ~pwe;
         sbq.push_back(e);
      end
      model_step(r, pwe, bw, a, d);
      if (r) known = 1;
   endtask

   task automatic wr(logic [14:0] a, logic [7:0] d);
      drive(0, pwe_cur, 1, a, d);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++)
         drive(0, pwe_cur, 0, 15'($urandom), 8'($urandom));
   endtask

   task automatic do_reset(int n);
      for (int i = 0; i < n; i++) drive(1, pwe_cur, 0, '0, '0);
   endtask

   task automatic prog_seq(logic [7:0] v);
      wr(15'h0AAA, 8'hAA); wr(15'h0555, 8'h55); wr(15'h0AAA, 8'hA0); wr(15'h1234, v);
   endtask

   task automatic erase_pre();
      wr(15'h0AAA, 8'hAA); wr(15'h0555, 8'h55); wr(15'h0AAA, 8'h80);
      wr(15'h0AAA, 8'hAA); wr(15'h0555, 8'h55);
   endtask

   task automatic chk(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge m2);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("busy",  busy,           e.busy);
            chk("done",  done,           e.done);
            chk("error", error,          e.error);
            chk("block", flash_we_block, e.block);
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      do_reset(2);
      // Program
      prog_seq(8'h5A); idle(45);
      // Sector and chip erase
      erase_pre(); wr(15'h2000, 8'h30); idle(105);
      erase_pre(); wr(15'h0AAA, 8'h10); idle(205);
      // Broken unlock then a good program
      wr(15'h0AAA, 8'hAA); wr(15'h0554, 8'h55); idle(2);
      prog_seq(8'h11); idle(45);
      // Write during busy, then clear in IDLE
      prog_seq(8'h22); idle(4); wr(15'h0000, 8'h12); idle(40);
      wr(15'h0000, 8'hF0); idle(2);
      // Abort from E_U1 by dropping the enable
      wr(15'h0AAA, 8'hAA); wr(15'h0555, 8'h55); wr(15'h0AAA, 8'h80); wr(15'h0AAA, 8'hAA);
      pwe_cur = 0; idle(3); pwe_cur = 1; idle(2);
      // Reset mid-busy
      prog_seq(8'h33); idle(9); do_reset(1); idle(3);
      // Autoselect
      wr(15'h0AAA, 8'hAA); wr(15'h0555, 8'h55); wr(15'h0AAA, 8'h90);
      wr(15'h0000, 8'h30); idle(2); wr(15'h0000, 8'hF0);
      prog_seq(8'h44); idle(45);
      // Timeout coinciding with a write
      prog_seq(8'h55); idle(PT - 1); wr(15'h0000, 8'h12); idle(2);
      wr(15'h0000, 8'hF0); idle(2);
      // F0 inside an unlock sequence aborts it but leaves error alone
      prog_seq(8'h66); wr(15'h0100, 8'h77); idle(PT);
      wr(15'h0AAA, 8'hAA); wr(15'h0000, 8'hF0); idle(2);
      wr(15'h0000, 8'hF0); idle(1);

      // Randomized command sequences with occasional corruption
      for (int s = 0; s < 60; s++) begin
         int kind;
         int n;
         kind = $urandom_range(0, 4);
         n = (kind == 4) ? 1 : tlen[kind];
         for (int i = 0; i < n; i++) begin
            logic [14:0] a;
            logic [7:0]  d;
            int tk;
            tk = (kind == 4) ? (($urandom_range(0, 1) == 0) ? 'h0F0 : 'h312) : tmpl[kind][i];
            a = {3'($urandom), 12'($urandom)};
            d = 8'($urandom);
            if (tk[9:8] != 2'd3) begin
               d = tk[7:0];
               if (tk[9:8] == 2'd1) a[11:0] = 12'hAAA;
               if (tk[9:8] == 2'd2) a[11:0] = 12'h555;
            end
            if ($urandom_range(0, 99) < 8) d[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 99) < 5) a[$urandom_range(0, 11)] ^= 1'b1;
            wr(a, d);
            idle($urandom_range(0, 3));
         end
         if ($urandom_range(0, 99) < 6) begin
            pwe_cur = 0; idle($urandom_range(1, 3)); pwe_cur = 1;
         end
         if ($urandom_range(0, 99) < 4) do_reset(1);
         idle($urandom_range(0, 250));
      end

      idle(2);
      @(negedge m2);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
